// File: rtl/cla_bist_pkg.sv
// Shared types and constants for the carry-lookahead adder BIST engine.
package cla_bist_pkg;

  localparam int unsigned OPW = 16;
  localparam logic [OPW-1:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // An all-zero Galois LFSR never leaves zero, so substitute 1.
  function automatic logic [OPW-1:0] seed_fix(input logic [OPW-1:0] s);
    return (s == '0) ? {{(OPW-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/cla_bist_lfsr16.sv
// 16-bit right-shifting Galois LFSR with seed load and step enable.
module lfsr16
  import cla_bist_pkg::*;
#(
  parameter logic [OPW-1:0] SEED = 16'h0001
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  output logic [OPW-1:0] state
);

  localparam logic [OPW-1:0] SEED_EFF = seed_fix(SEED);

  logic [OPW-1:0] state_q;
  logic [OPW-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED_EFF;
    end else if (step) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_MASK : '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/cla_bist.sv
// BIST engine for the 16-bit CLA: drives LFSR operands, checks sum/cOut.
// First-fail capture built only when CLA_BIST_FIRST_FAIL_EN is defined.
module cla_bist
  import cla_bist_pkg::*;
#(
  parameter int unsigned    NUM_VECTORS = 256,
  parameter logic [OPW-1:0] SEED_A      = 16'hACE1,
  parameter logic [OPW-1:0] SEED_B      = 16'h1D2B
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [OPW-1:0] in1,
  output logic [OPW-1:0] in2,
  output logic           cIn,
  input  logic [OPW-1:0] sum,
  input  logic           cOut,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [OPW-1:0] err_count,
  output logic [OPW-1:0] fail_idx,
  output logic [OPW-1:0] fail_a,
  output logic [OPW-1:0] fail_b
);

  localparam logic [OPW-1:0] LAST_VEC = OPW'(NUM_VECTORS - 1);

  state_e         state_q;
  state_e         state_d;
  logic [OPW-1:0] vec_cnt_q;
  logic [OPW-1:0] vec_cnt_d;
  logic [OPW-1:0] err_count_q;
  logic [OPW-1:0] err_count_d;

  logic           load;
  logic           step;
  logic [OPW:0]   golden;
  logic           mismatch;

  assign load = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign step = (state_q == ST_CHECK);

  lfsr16 #(.SEED(SEED_A)) u_lfsr_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .state (in1)
  );

  lfsr16 #(.SEED(SEED_B)) u_lfsr_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .state (in2)
  );

  assign cIn = in1[0] ^ in2[0];

  always_comb begin
    golden   = {1'b0, in1} + {1'b0, in2} + {{OPW{1'b0}}, cIn};
    mismatch = (sum != golden[OPW-1:0]) || (cOut != golden[OPW]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_DRIVE;
      ST_DRIVE: state_d = ST_CHECK;
      ST_CHECK: state_d = (vec_cnt_q == LAST_VEC) ? ST_DONE : ST_DRIVE;
      ST_DONE:  if (start) state_d = ST_DRIVE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    done = (state_q == ST_DONE);
    pass = done && (err_count_q == '0);
  end

  always_comb begin
    vec_cnt_d   = vec_cnt_q;
    err_count_d = err_count_q;
    if (load) begin
      vec_cnt_d   = '0;
      err_count_d = '0;
    end else if (step) begin
      vec_cnt_d = vec_cnt_q + 1'b1;
      if (mismatch && err_count_q != '1) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_cnt_q   <= '0;
      err_count_q <= '0;
    end else begin
      vec_cnt_q   <= vec_cnt_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;

`ifdef CLA_BIST_FIRST_FAIL_EN
  logic [OPW-1:0] fail_idx_q;
  logic [OPW-1:0] fail_idx_d;
  logic [OPW-1:0] fail_a_q;
  logic [OPW-1:0] fail_a_d;
  logic [OPW-1:0] fail_b_q;
  logic [OPW-1:0] fail_b_d;

  // A zero error count marks the first mismatch of the run; saturation never returns it to zero.
  always_comb begin
    fail_idx_d = fail_idx_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    if (load) begin
      fail_idx_d = '0;
      fail_a_d   = '0;
      fail_b_d   = '0;
    end else if (step && mismatch && err_count_q == '0) begin
      fail_idx_d = vec_cnt_q;
      fail_a_d   = in1;
      fail_b_d   = in2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_idx_q <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
    end else begin
      fail_idx_q <= fail_idx_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
    end
  end

  assign fail_idx = fail_idx_q;
  assign fail_a   = fail_a_q;
  assign fail_b   = fail_b_q;
`else
  assign fail_idx = '0;
  assign fail_a   = '0;
  assign fail_b   = '0;
`endif

endmodule

// File: tb/tb_cla_bist.sv
// Directed bench for cla_bist with a faultable behavioural adder beside each instance.
module tb_cla_bist;

  logic        clk;
  logic        rst;

  logic        start;
  logic [15:0] in1, in2, sum;
  logic        cIn, cOut;
  logic        busy, done, pass;
  logic [15:0] err_count, fail_idx, fail_a, fail_b;
  int unsigned fault_mode;

  logic        z_start;
  logic [15:0] z_in1, z_in2, z_sum;
  logic        z_cIn, z_cOut;
  logic        z_busy, z_done, z_pass;
  logic [15:0] z_err_count, z_fail_idx, z_fail_a, z_fail_b;
  int unsigned z_fault_mode;

  int unsigned n_cmp;
  int unsigned n_err;

  cla_bist #(.NUM_VECTORS(16), .SEED_A(16'hACE1), .SEED_B(16'h1D2B)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .in1(in1), .in2(in2), .cIn(cIn), .sum(sum), .cOut(cOut),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_idx(fail_idx), .fail_a(fail_a), .fail_b(fail_b)
  );

  cla_bist #(.NUM_VECTORS(4), .SEED_A(16'h0000), .SEED_B(16'hFFFF)) u_dut_z (
    .clk(clk), .rst(rst), .start(z_start),
    .in1(z_in1), .in2(z_in2), .cIn(z_cIn), .sum(z_sum), .cOut(z_cOut),
    .busy(z_busy), .done(z_done), .pass(z_pass), .err_count(z_err_count),
    .fail_idx(z_fail_idx), .fail_a(z_fail_a), .fail_b(z_fail_b)
  );

  // Adder models: mode 1 = sum[0] stuck at 0, mode 2 = cOut stuck at 0.
  logic [16:0] full, z_full;
  always_comb begin
    full = {1'b0, in1} + {1'b0, in2} + {16'h0000, cIn};
    sum  = full[15:0];
    cOut = full[16];
    if (fault_mode == 1) sum[0] = 1'b0;
    if (fault_mode == 2) cOut = 1'b0;
  end

  always_comb begin
    z_full = {1'b0, z_in1} + {1'b0, z_in2} + {16'h0000, z_cIn};
    z_sum  = z_full[15:0];
    z_cOut = z_full[16];
    if (z_fault_mode == 1) z_sum[0] = 1'b0;
    if (z_fault_mode == 2) z_cOut = 1'b0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Tap-by-tap form of x^16+x^14+x^13+x^11+1, right-shifting.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n      = {1'b0, s[15:1]};
    n[15]  = s[0];
    n[13]  = s[14] ^ s[0];
    n[12]  = s[13] ^ s[0];
    n[10]  = s[11] ^ s[0];
    return n;
  endfunction

  task automatic model_run(input logic [15:0] sa, input logic [15:0] sb, input int unsigned n,
                           input int unsigned mode, output int unsigned cnt,
                           output logic [15:0] fidx, output logic [15:0] fa, output logic [15:0] fb);
    logic [15:0] a, b;
    logic [16:0] g;
    logic        bad;
    a    = (sa == 16'h0) ? 16'h0001 : sa;
    b    = (sb == 16'h0) ? 16'h0001 : sb;
    cnt  = 0;
    fidx = '0;
    fa   = '0;
    fb   = '0;
    for (int unsigned i = 0; i < n; i++) begin
      g   = a + b + (a[0] ^ b[0]);
      bad = (mode == 1) ? g[0] : (mode == 2) ? g[16] : 1'b0;
      if (bad) begin
        if (cnt == 0) begin
          fidx = 16'(i);
          fa   = a;
          fb   = b;
        end
        cnt++;
      end
      a = lfsr_step(a);
      b = lfsr_step(b);
    end
  endtask

  // Pulse start; returns the number of edges after acceptance until done is seen.
  task automatic run_main(input int unsigned poke_k, output int unsigned k_done);
    int unsigned k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1'b1);
    k = 0;
    while (!done && k < 200) begin
      if (k == poke_k) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    k_done = k;
  endtask

  int unsigned kd, exp_cnt, z_cnt1;
  logic [15:0] e_idx, e_a, e_b;

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b0;
    start        = 1'b0;
    z_start      = 1'b0;
    fault_mode   = 0;
    z_fault_mode = 1;
    repeat (2) @(negedge clk);

    chk("rst_in1", in1, 16'hACE1);
    chk("rst_in2", in2, 16'h1D2B);
    chk("rst_cin", cIn, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err", err_count, 16'h0);
    chk("rst_fidx", fail_idx, 16'h0);
    chk("z_rst_in1", z_in1, 16'h0001);
    chk("z_rst_in2", z_in2, 16'hFFFF);
    rst = 1'b1;
    @(negedge clk);

    // Correct adder, 16 vectors
    run_main(1000, kd);
    chk("ok_latency", kd, 32);
    chk("ok_pass", pass, 1'b1);
    chk("ok_err", err_count, 16'h0);
    chk("ok_fidx", fail_idx, 16'h0);
    chk("ok_busy_low", busy, 1'b0);

    // sum[0] stuck at 0
    fault_mode = 1;
    model_run(16'hACE1, 16'h1D2B, 16, 1, exp_cnt, e_idx, e_a, e_b);
    run_main(1000, kd);
    chk("s0_latency", kd, 32);
    chk("s0_err", err_count, exp_cnt);
    chk("s0_pass", pass, (exp_cnt == 0));
`ifdef CLA_BIST_FIRST_FAIL_EN
    chk("s0_fidx", fail_idx, e_idx);
    chk("s0_fa", fail_a, e_a);
    chk("s0_fb", fail_b, e_b);
`else
    chk("s0_fa_tied", fail_a, 16'h0);
    chk("s0_fb_tied", fail_b, 16'h0);
`endif

    // cOut stuck at 0: only carry vectors count
    fault_mode = 2;
    model_run(16'hACE1, 16'h1D2B, 16, 2, exp_cnt, e_idx, e_a, e_b);
    run_main(1000, kd);
    chk("co_err", err_count, exp_cnt);
    chk("co_pass", pass, (exp_cnt == 0));

    // start pulsed during CHECK of vector 2 is ignored
    fault_mode = 0;
    run_main(5, kd);
    chk("poke_latency", kd, 32);
    chk("poke_err", err_count, 16'h0);
    chk("poke_pass", pass, 1'b1);

    // Reset mid-run with errors already counted (vector 1 carries out)
    fault_mode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_err_pre", (err_count != 16'h0), 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_err", err_count, 16'h0);
    chk("mid_in1", in1, 16'hACE1);
    chk("mid_in2", in2, 16'hBA95 ^ 16'hBA95 ^ 16'h1D2B);
    chk("mid_fa", fail_a, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    fault_mode = 0;
    @(negedge clk);

    // Fresh start reproduces the sequence: vector 1 = E270/BA95, cIn 1
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("seq_v0_in1", in1, 16'hACE1);
    chk("seq_v0_sum", sum, 16'hCA0C);
    repeat (2) @(negedge clk);
    chk("seq_v1_in1", in1, 16'hE270);
    chk("seq_v1_in2", in2, 16'hBA95);
    chk("seq_v1_cin", cIn, 1'b1);
    kd = 2;
    while (!done && kd < 200) begin
      @(negedge clk);
      kd++;
    end
    chk("seq_latency", kd, 32);

    // Zero SEED_A instance, start held high through DONE
    model_run(16'h0000, 16'hFFFF, 4, 1, exp_cnt, e_idx, e_a, e_b);
    z_start = 1'b1;
    @(negedge clk);
    chk("z_first_in1", z_in1, 16'h0001);
    kd = 0;
    while (!z_done && kd < 50) begin
      @(negedge clk);
      kd++;
    end
    chk("z_latency", kd, 8);
    chk("z_err1", z_err_count, exp_cnt);
    z_cnt1 = z_err_count;
    @(negedge clk);
    chk("z_restart_done", z_done, 1'b0);
    chk("z_restart_busy", z_busy, 1'b1);
    chk("z_restart_in1", z_in1, 16'h0001);
    kd = 0;
    while (!z_done && kd < 50) begin
      @(negedge clk);
      kd++;
    end
    z_start = 1'b0;
    chk("z_latency2", kd, 8);
    chk("z_err2", z_err_count, z_cnt1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
